// File: rtl/jtag_master_pkg.sv
// ============================================================================
// Module : jtag_master_pkg
// Brief  : Shared types, FSM encodings and TMS patterns for the JTAG scan master
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jtag_master_pkg;

  typedef enum logic [1:0] {
    OP_RESET   = 2'b00,
    OP_SCAN_IR = 2'b01,
    OP_SCAN_DR = 2'b10,
    OP_IDLE    = 2'b11
  } op_e;

  typedef logic [2:0] state_e;

  localparam state_e ST_IDLE  = 3'd0;
  localparam state_e ST_TRST  = 3'd1;
  localparam state_e ST_HDR   = 3'd2;
  localparam state_e ST_SHIFT = 3'd3;
  localparam state_e ST_TAIL  = 3'd4;
  localparam state_e ST_RUNI  = 3'd5;
  localparam state_e ST_DONE  = 3'd6;

  // TMS patterns are stored LSB-first: bit i is driven on the i-th TCK of the phase.
  localparam logic [2:0] HDR_DR   = 3'b001;
  localparam logic [3:0] HDR_IR   = 4'b0011;
  localparam logic [1:0] TAIL     = 2'b01;
  localparam logic [5:0] TRST_TMS = 6'b011111;

  function automatic logic tms_bit(input state_e st, input logic [4:0] idx,
                                   input op_e op, input logic [4:0] len);
    logic r;
    r = 1'b0;
    case (st)
      ST_TRST:  r = TRST_TMS[idx[2:0]];
      ST_HDR:   r = (op == OP_SCAN_IR) ? HDR_IR[idx[1:0]] : HDR_DR[idx[1:0]];
      ST_SHIFT: r = (idx == len);
      ST_TAIL:  r = TAIL[idx[0]];
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tck_gen.sv
// ============================================================================
// Module : tck_gen
// Brief  : TCK divider with pre-edge strobes; tck parks low whenever run is low
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic run,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          last;

  // Strobes are high in the cycle whose closing edge flips tck.
  assign last     = run && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_stb = last && !tck_q;
  assign fall_stb = last && tck_q;
  assign tck      = tck_q;

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!run) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtag_scan_master.sv
// ============================================================================
// Module : jtag_scan_master
// Brief  : Command-driven JTAG sequencer: TAP reset, IR/DR scans and idle clocks
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jtag_scan_master
  import jtag_master_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [4:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trst,
  input  logic               tdo
);

  state_e             state_q, state_d;
  logic [4:0]         bit_q, bit_d;
  op_e                op_q, op_d;
  logic [4:0]         len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               trst_q, trst_d;

  logic   run, fall_stb, rise_stb, adv;
  state_e nstate;
  logic [4:0] nbit;

  // TCK is held off for the first cycle after reset so trst deasserts first.
  assign run = trst_q && (state_q inside {ST_TRST, ST_HDR, ST_SHIFT, ST_TAIL, ST_RUNI});

  tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .run      (run),
    .tck      (tck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    op_d        = op_q;
    len_d       = len_q;
    data_d      = data_q;
    cap_d       = cap_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    trst_d      = 1'b1;
    adv         = 1'b0;
    nstate      = state_q;
    nbit        = bit_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          len_d  = cmd_len;
          data_d = cmd_data;
          cap_d  = '0;
          adv    = 1'b1;
          nbit   = 5'd0;
          case (op_e'(cmd_op))
            OP_RESET:               nstate = ST_TRST;
            OP_SCAN_IR, OP_SCAN_DR: nstate = ST_HDR;
            default:                nstate = ST_RUNI;
          endcase
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if ((op_q == OP_SCAN_IR) || (op_q == OP_SCAN_DR)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = cap_q;
        end
      end
      ST_TRST, ST_HDR, ST_SHIFT, ST_TAIL, ST_RUNI: begin
        if (rise_stb && (state_q == ST_SHIFT)) cap_d[bit_q] = tdo;
        if (fall_stb) begin
          adv  = 1'b1;
          nbit = bit_q + 5'd1;
          case (state_q)
            ST_TRST: if (bit_q == 5'd5) begin
              nstate = ST_DONE;
              nbit   = 5'd0;
            end
            ST_HDR: if (bit_q == ((op_q == OP_SCAN_IR) ? 5'd3 : 5'd2)) begin
              nstate = ST_SHIFT;
              nbit   = 5'd0;
            end
            ST_SHIFT: if (bit_q == len_q) begin
              nstate = ST_TAIL;
              nbit   = 5'd0;
            end
            ST_TAIL: if (bit_q == 5'd1) begin
              nstate = ST_DONE;
              nbit   = 5'd0;
            end
            default: if (bit_q == len_q) begin
              nstate = ST_DONE;
              nbit   = 5'd0;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // TMS/TDI for the upcoming TCK period are launched with the falling edge.
    if (adv) begin
      state_d = nstate;
      bit_d   = nbit;
      tms_d   = tms_bit(nstate, nbit, op_d, len_d);
      tdi_d   = (nstate == ST_SHIFT) ? data_d[nbit] : 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= ST_TRST;
      bit_q       <= 5'd0;
      op_q        <= OP_RESET;
      len_q       <= 5'd0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      trst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      op_q        <= op_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      trst_q      <= trst_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trst      = trst_q;

endmodule

`default_nettype wire

// File: tb/tb_jtag_scan_master.sv
// ============================================================================
// Module : tb_jtag_scan_master
// Brief  : Scoreboard bench for jtag_scan_master with a bypass-register TAP model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jtag_scan_master;

  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 32;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [4:0]         cmd_len = 5'd0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy, tck, tms, tdi, trst;
  logic               tdo = 1'b0;
  logic               byp = 1'b0;

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  logic [31:0] exp_q[$];
  logic tms_log[$];
  logic tdi_log[$];

  jtag_scan_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .trst      (trst),
    .tdo       (tdo)
  );

  always #5 sys_clk = ~sys_clk;

  // Bypass-style TAP: one-bit register captured on rising TCK, driven out on falling TCK.
  always @(posedge tck) begin
    byp <= tdi;
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
  end
  always @(negedge tck) tdo <= byp;

  always @(negedge sys_clk) begin
    logic [31:0] e;
    if (rsp_valid) begin
      rsp_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp got=%h expected no response", rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e || cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL rsp_data got=%h ready=%b expected=%h ready=1", rsp_data, cmd_ready, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic chk_log(input string name, input logic [63:0] exp_tms,
                         input logic [63:0] exp_tdi, input int exp_n);
    logic [63:0] t, d;
    t = '0;
    d = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) begin
      t[i] = tms_log[i];
      d[i] = tdi_log[i];
    end
    chk({name, "_tck_count"}, 64'(tms_log.size()), 64'(exp_n));
    chk({name, "_tms"}, t, exp_tms);
    chk({name, "_tdi"}, d, exp_tdi);
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n;
    n = 0;
    while (!cmd_ready && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout got=0 expected=1", name);
    end
  endtask

  task automatic run_cmd(input string name, input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, input bit has_rsp,
                         input logic [31:0] exp_rsp, input int exp_busy);
    int n;
    wait_ready(name, 500);
    tms_log.delete();
    tdi_log.delete();
    if (has_rsp) exp_q.push_back(exp_rsp);
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge sys_clk);
    end
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
  endtask

  initial begin
    int n;

    // Reset values and automatic TAP reset after release
    repeat (3) @(negedge sys_clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_trst", trst, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 1);
    tms_log.delete();
    tdi_log.delete();
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("trst_release", trst, 1);
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk("reset_ready_latency", 64'(n), 64'd25);
    chk_log("auto_reset", 64'h1F, 64'h0, 6);
    chk("auto_reset_no_rsp", 64'(rsp_seen), 64'd0);

    // IR scan, 4 bits of 4'b0010
    run_cmd("ir4", 2'b01, 5'd3, 32'h2, 1'b1, 32'h4, 41);
    chk_log("ir4", 64'h183, 64'h020, 10);

    // DR scan, 32 bits through the bypass model
    run_cmd("dr32", 2'b10, 5'd31, 32'hA5A5_0F0F, 1'b1, 32'h4B4A_1E1E, 149);
    chk_log("dr32", 64'h0000_000C_0000_0001, 64'h0000_0005_2D28_7878, 37);

    // Idle clocks; previous scan result must persist
    run_cmd("idle5", 2'b11, 5'd4, 32'hFFFF_FFFF, 1'b0, 32'h0, 21);
    chk_log("idle5", 64'h0, 64'h0, 5);
    chk("rsp_hold_after_idle", rsp_data, 32'h4B4A_1E1E);

    // Single-bit DR scan: TMS high on the only shift bit
    run_cmd("dr1", 2'b10, 5'd0, 32'h1, 1'b1, 32'h0, 25);
    chk_log("dr1", 64'h19, 64'h08, 6);

    // cmd_valid held through a busy scan with a different op
    wait_ready("ignore", 500);
    tms_log.delete();
    tdi_log.delete();
    exp_q.push_back(32'hB4);
    cmd_op    = 2'b10;
    cmd_len   = 5'd7;
    cmd_data  = 32'h5A;
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_op   = 2'b11;
    cmd_len  = 5'd2;
    cmd_data = 32'hFFFF_FFFF;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge sys_clk);
    end
    chk("ignore_dr8_busy_cycles", 64'(n), 64'd53);
    chk_log("ignore_dr8", 64'hC01, 64'h2D0, 13);
    tms_log.delete();
    tdi_log.delete();
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge sys_clk);
    end
    chk("queued_idle3_busy_cycles", 64'(n), 64'd13);
    chk_log("queued_idle3", 64'h0, 64'h0, 3);

    // Asynchronous reset in the middle of a shift
    wait_ready("abort", 500);
    cmd_op    = 2'b10;
    cmd_len   = 5'd15;
    cmd_data  = 32'hFFFF;
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_tdi", tdi, 0);
    chk("abort_trst", trst, 0);
    chk("abort_busy", busy, 1);
    chk("abort_rsp_data", rsp_data, 0);
    tms_log.delete();
    tdi_log.delete();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    wait_ready("abort_rerun", 500);
    chk_log("abort_rerun", 64'h1F, 64'h0, 6);
    repeat (10) @(negedge sys_clk);
    chk("total_rsp_pulses", 64'(rsp_seen), 64'd4);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
